// File: rtl/pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// pipe_skid_stage
//
// Elastic pipeline register with a two-entry skid buffer. It carries one
// WIDTH-bit stage bundle per entry across a valid/ready handshake. It can
// replace a fixed register bank at any stage boundary of the core.
//
// i_in_ready is computed from registered state and i_en only. It never looks
// at i_out_ready, so the ready path is broken at every stage boundary.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset; drops all held data
//   i_clr        synchronous active-low flush; takes priority over i_en
//   i_en         stage enable; 0 freezes all state and blocks both handshakes
//   i_in_valid   upstream presents data
//   o_in_ready   stage can accept this cycle
//   i_in_data    upstream bundle
//   o_out_valid  stage presents data
//   i_out_ready  downstream accepts
//   o_out_data   bundle held in the main entry
//   o_occupancy  number of entries held (0, 1 or 2)
//   o_stall_cnt  saturating count of cycles with valid output and no ready
//   i_cnt_clr    synchronous active-high clear of o_stall_cnt
// ---------------------------------------------------------------------------
module pipe_skid_stage #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic [1:0]       o_occupancy,
  output logic [CNT_W-1:0] o_stall_cnt,
  input  logic             i_cnt_clr
);

  // The state encoding is {skid valid, main valid}. The value 2'b10 is not
  // part of the enum, so the skid entry can never be valid while the main
  // entry is empty.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } stateT;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  stateT            r_state;
  stateT            w_stateNext;
  logic [WIDTH-1:0] r_mainData;
  logic [WIDTH-1:0] r_skidData;
  logic [WIDTH-1:0] w_mainDataNext;
  logic [WIDTH-1:0] w_skidDataNext;
  logic [CNT_W-1:0] r_stallCnt;

  logic w_mainValid;
  logic w_skidValid;
  logic w_inXfer;
  logic w_outXfer;

  assign w_mainValid = (r_state != EMPTY);
  assign w_skidValid = (r_state == FULL);

  assign o_in_ready  = i_en & ~w_skidValid;
  assign o_out_valid = i_en & w_mainValid;
  assign o_out_data  = r_mainData;
  assign o_occupancy = {1'b0, w_mainValid} + {1'b0, w_skidValid};
  assign o_stall_cnt = r_stallCnt;

  assign w_inXfer  = i_in_valid & o_in_ready;
  assign w_outXfer = o_out_valid & i_out_ready;

  // This block computes the next state and the next data entries. A flush
  // overrides everything else, including an input transfer in the same cycle.
  // Both transfer terms already include i_en, so a frozen stage falls through
  // to hold.
  always_comb begin
    w_stateNext    = r_state;
    w_mainDataNext = r_mainData;
    w_skidDataNext = r_skidData;
    if (!i_clr) begin
      w_stateNext    = EMPTY;
      w_mainDataNext = RESET_VALUE;
      w_skidDataNext = RESET_VALUE;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_inXfer) begin
            w_stateNext    = ONE;
            w_mainDataNext = i_in_data;
          end
        end
        ONE: begin
          if (w_inXfer && w_outXfer) begin
            w_mainDataNext = i_in_data;
          end else if (w_inXfer) begin
            w_stateNext    = FULL;
            w_skidDataNext = i_in_data;
          end else if (w_outXfer) begin
            w_stateNext = EMPTY;
          end
        end
        FULL: begin
          // In this state o_in_ready is 0, so the only possible event is
          // draining the main entry and promoting the skid entry.
          if (w_outXfer) begin
            w_stateNext    = ONE;
            w_mainDataNext = r_skidData;
          end
        end
        default: begin
          w_stateNext = EMPTY;
        end
      endcase
    end
  end

  // This block holds the state and data registers. Reset is asynchronous and
  // discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_mainData <= RESET_VALUE;
      r_skidData <= RESET_VALUE;
    end else begin
      r_state    <= w_stateNext;
      r_mainData <= w_mainDataNext;
      r_skidData <= w_skidDataNext;
    end
  end

  // The stall counter counts cycles where the stage offers data and the
  // downstream refuses it. It saturates rather than wraps. The clear takes
  // priority over an increment. A flush does not clear the counter, but the
  // counter also does not increment during a flush cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCnt <= '0;
    end else if (i_cnt_clr) begin
      r_stallCnt <= '0;
    end else if (i_en && w_mainValid && !i_out_ready && i_clr &&
                 (r_stallCnt != CNT_MAX)) begin
      r_stallCnt <= r_stallCnt + 1'b1;
    end
  end

endmodule
